// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ysyx_22041211_ifu_pkg;

    // REQ: request driven. WAIT: response outstanding. HOLD: instruction presented to IDU.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned PC_STEP          = 4;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_pc_reg.sv
// Architectural PC register: reset value, redirect target, or sequential step.
module ysyx_22041211_ifu_pc_reg
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int unsigned          DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_i,
    input  logic [DATA_LEN-1:0] redirect_pc_i,
    input  logic                advance_i,
    output logic [DATA_LEN-1:0] pc_o
);

    logic [DATA_LEN-1:0] pc_q;
    logic [DATA_LEN-1:0] pc_d;

    // Redirect wins over the sequential step; the add wraps modulo 2^DATA_LEN.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + DATA_LEN'(PC_STEP);
        end
    end

    // PC storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22041211_ifu_fetch.sv
// Instruction-fetch front end: one outstanding imem request, response captured
// and held for IDU. Optional performance counters are built when the macro
// IFU_PERF_CNT_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid does not depend on ready, and payload is stable while valid waits.
// The imem address may change before acceptance (redirect in REQ).
module ysyx_22041211_ifu_fetch
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int unsigned          DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [DATA_LEN-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [DATA_LEN-1:0] imem_resp_data,
    input  logic                imem_resp_err,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
    output logic [DATA_LEN-1:0] inst_pc,
    output logic                fetch_fault,
`ifdef IFU_PERF_CNT_EN
    output logic [63:0]         perf_fetch_cnt,
    output logic [63:0]         perf_stall_cnt,
`endif
    output ifu_state_e          dbg_state_o
);

    ifu_state_e          state_q;
    logic                drop_q;
    logic [DATA_LEN-1:0] inst_q;
    logic [DATA_LEN-1:0] inst_pc_q;
    logic                fault_q;
    logic [DATA_LEN-1:0] pc;
    logic [DATA_LEN-1:0] target;
    logic                advance;

    // Sequential step only on an accepted instruction; redirect priority is inside pc_reg.
    assign advance = (state_q == HOLD) && inst_ready && !rst;

    ysyx_22041211_ifu_pc_reg #(
        .DATA_LEN (DATA_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_o          (pc)
    );

    // Where a dropped response leaves us: the redirect arriving now, or the one already latched in pc.
    assign target = redirect_valid ? redirect_pc : pc;

    // Fetch FSM with registered instruction payload; misaligned targets become a held fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (redirect_valid && is_misaligned(redirect_pc[1:0]) && !imem_req_ready) begin
                        state_q   <= HOLD;
                        inst_q    <= '0;
                        inst_pc_q <= redirect_pc;
                        fault_q   <= 1'b1;
                    end else if (imem_req_ready) begin
                        state_q <= WAIT;
                        drop_q  <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        drop_q <= 1'b0;
                        if (drop_q || redirect_valid) begin
                            if (is_misaligned(target[1:0])) begin
                                state_q   <= HOLD;
                                inst_q    <= '0;
                                inst_pc_q <= target;
                                fault_q   <= 1'b1;
                            end else begin
                                state_q <= REQ;
                            end
                        end else begin
                            state_q   <= HOLD;
                            inst_q    <= imem_resp_data;
                            inst_pc_q <= pc;
                            fault_q   <= imem_resp_err;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        if (is_misaligned(redirect_pc[1:0])) begin
                            inst_q    <= '0;
                            inst_pc_q <= redirect_pc;
                            fault_q   <= 1'b1;
                        end else begin
                            state_q <= REQ;
                        end
                    end else if (inst_ready) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end

    assign imem_req_valid = !rst && (state_q == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = !rst && (state_q == HOLD);
    assign inst           = rst ? '0 : inst_q;
    assign inst_pc        = rst ? '0 : inst_pc_q;
    assign fetch_fault    = !rst && fault_q;
    assign dbg_state_o    = state_q;

    // Responses are only legal while one is outstanding.
    a_resp_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) imem_resp_valid |-> (state_q == WAIT)
    );

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q;
    logic [63:0] stall_cnt_q;

    // Count delivered instructions and cycles spent waiting on memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (inst_valid && inst_ready) begin
                fetch_cnt_q <= fetch_cnt_q + 64'd1;
            end
            if (((state_q == REQ) && !imem_req_ready) || ((state_q == WAIT) && !imem_resp_valid)) begin
                stall_cnt_q <= stall_cnt_q + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22041211_ifu_fetch.sv
// Bench for the instruction-fetch front end: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ysyx_22041211_ifu_fetch;
    import ysyx_22041211_ifu_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] RST_PC = 32'h8000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         imem_req_valid;
    logic         imem_req_ready = 1'b0;
    logic [W-1:0] imem_req_addr;
    logic         imem_resp_valid = 1'b0;
    logic [W-1:0] imem_resp_data = '0;
    logic         imem_resp_err = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic         inst_valid;
    logic         inst_ready = 1'b0;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
    logic         fetch_fault;
    ifu_state_e   dbg_state;

    ysyx_22041211_ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault),
        .dbg_state_o     (dbg_state)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- transaction-level model ----------------
    // m_out: a request was accepted and its response is still due.
    // m_disc: that response belongs to a superseded PC and must be thrown away.
    // m_item_v/m_inst/m_ipc/m_fault: the instruction currently offered to IDU.
    logic [W-1:0] m_pc = RST_PC;
    logic         m_out = 1'b0;
    logic         m_disc = 1'b0;
    logic         m_item_v = 1'b0;
    logic [W-1:0] m_inst = '0;
    logic [W-1:0] m_ipc = '0;
    logic         m_fault = 1'b0;

    task automatic load_fault(input logic [W-1:0] a);
        m_item_v = 1'b1;
        m_inst   = '0;
        m_ipc    = a;
        m_fault  = 1'b1;
    endtask

    task automatic model_step();
        logic [W-1:0] tgt;
        if (rst) begin
            m_pc = RST_PC; m_out = 1'b0; m_disc = 1'b0;
            m_item_v = 1'b0; m_inst = '0; m_ipc = '0; m_fault = 1'b0;
            return;
        end
        if (!m_out && !m_item_v) begin
            if (redirect_valid) begin
                m_pc = redirect_pc;
                if (imem_req_ready) begin
                    m_out = 1'b1; m_disc = 1'b1;
                end else if (redirect_pc[1:0] != 2'b00) begin
                    load_fault(redirect_pc);
                end
            end else if (imem_req_ready) begin
                m_out = 1'b1; m_disc = 1'b0;
            end
        end else if (m_out) begin
            tgt = redirect_valid ? redirect_pc : m_pc;
            if (imem_resp_valid) begin
                m_out = 1'b0;
                if (m_disc || redirect_valid) begin
                    m_disc = 1'b0;
                    if (tgt[1:0] != 2'b00) load_fault(tgt);
                end else begin
                    m_item_v = 1'b1; m_inst = imem_resp_data; m_ipc = m_pc; m_fault = imem_resp_err;
                end
            end else if (redirect_valid) begin
                m_disc = 1'b1;
            end
            if (redirect_valid) m_pc = redirect_pc;
        end else begin
            if (redirect_valid) begin
                m_item_v = 1'b0;
                m_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) load_fault(redirect_pc);
            end else if (inst_ready) begin
                m_item_v = 1'b0;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_req_v;
        logic exp_inst_v;
        ifu_state_e exp_st;
        exp_req_v  = !rst && !m_out && !m_item_v;
        exp_inst_v = !rst && m_item_v;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req_v));
        if (exp_req_v) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(exp_inst_v));
        if (exp_inst_v) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_ipc);
            chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        end
        if (rst) begin
            chk("rst_inst", inst, '0);
            chk("rst_inst_pc", inst_pc, '0);
            chk("rst_fault", 32'(fetch_fault), '0);
        end else begin
            exp_st = m_item_v ? HOLD : (m_out ? WAIT : REQ);
            chk("state", 32'(dbg_state), 32'(exp_st));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // From REQ: accept the request, then return one response; ends in HOLD.
    task automatic fetch_to_hold(input logic [W-1:0] data, input logic err);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = data; imem_resp_err = err;
        tick();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    endtask

    logic [W-1:0] rpc;

    initial begin
        idle_inputs();

        // Reset, then zero-wait memory returning addi x0,x0,0.
        do_reset();
        chk("t1_addr0", imem_req_addr, 32'h8000_0000);
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t1_req_v", 32'(imem_req_valid), 32'd1);
            chk("t1_req_addr", imem_req_addr, RST_PC + 32'(4 * k));
            imem_req_ready = 1'b1;
            tick();
            chk("t1_wait_iv", 32'(inst_valid), 32'd0);
            imem_req_ready = 1'b0;
            imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
            tick();
            imem_resp_valid = 1'b0;
            chk("t1_iv", 32'(inst_valid), 32'd1);
            chk("t1_inst", inst, 32'h0000_0013);
            chk("t1_inst_pc", inst_pc, RST_PC + 32'(4 * k));
            tick();
        end

        // IDU stalls for five cycles: payload stable, no new request.
        do_reset();
        fetch_to_hold(32'h0010_0093, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t2_iv", 32'(inst_valid), 32'd1);
            chk("t2_inst", inst, 32'h0010_0093);
            chk("t2_inst_pc", inst_pc, 32'h8000_0000);
            chk("t2_fault", 32'(fetch_fault), 32'd0);
            chk("t2_req_v", 32'(imem_req_valid), 32'd0);
            chk("t2_pc", imem_req_addr, 32'h8000_0000);
            tick();
        end

        // Redirect while waiting: stale response discarded.
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef;
        tick();
        imem_resp_valid = 1'b0;
        chk("t3_iv", 32'(inst_valid), 32'd0);
        chk("t3_req_v", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h8000_1000);

        // Redirect coinciding with the IDU handshake.
        do_reset();
        fetch_to_hold(32'h0000_0013, 1'b0);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        tick();
        inst_ready = 1'b0; redirect_valid = 1'b0;
        chk("t4_req_v", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h8000_2000);
        chk("t4_iv", 32'(inst_valid), 32'd0);

        // Access fault, then misaligned redirect.
        do_reset();
        fetch_to_hold(32'h0000_0000, 1'b1);
        chk("t5_iv", 32'(inst_valid), 32'd1);
        chk("t5_fault", 32'(fetch_fault), 32'd1);
        chk("t5_inst_pc", inst_pc, 32'h8000_0000);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        chk("t5m_iv", 32'(inst_valid), 32'd1);
        chk("t5m_fault", 32'(fetch_fault), 32'd1);
        chk("t5m_inst_pc", inst_pc, 32'h8000_0002);
        chk("t5m_inst", inst, 32'h0);
        chk("t5m_req_v", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t5n_req_v", 32'(imem_req_valid), 32'd1);
        chk("t5n_req_addr", imem_req_addr, 32'h8000_0006);

        // PC wrap, then reset while a response is outstanding.
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        fetch_to_hold(32'h0000_0013, 1'b0);
        chk("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t6_wrap_v", 32'(imem_req_valid), 32'd1);
        chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("t6_wait_v", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0bad;
        tick();
        imem_resp_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_v", 32'(imem_req_valid), 32'd1);
        chk("t6_rst_addr", imem_req_addr, 32'h8000_0000);
        chk("t6_rst_iv", 32'(inst_valid), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst             = ($urandom_range(0, 149) == 0);
            imem_req_ready  = 1'($urandom_range(0, 1));
            imem_resp_valid = m_out && !rst && ($urandom_range(0, 2) == 0);
            imem_resp_data  = $urandom;
            imem_resp_err   = ($urandom_range(0, 7) == 0);
            redirect_valid  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            redirect_pc = rpc;
            inst_ready  = 1'($urandom_range(0, 1));
            tick();
        end

        // ---------------- final report ----------------
        idle_inputs();
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
